// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock, with on-the-fly forward/inverse key schedule.
// Optional key cache (last key and its k10, skips expansion on a repeat key): define AES_DEC_KEY_CACHE_EN.

module aes_gf_inv (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 by square-and-multiply: exponent runs 1,3,7,...,127 then one final square
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    p = a;
    for (int i = 0; i < 6; i++) p = gf_mul(gf_mul(p, p), a);
    return gf_mul(p, p);
  endfunction

  assign y_o = gf_inv(a_i);
endmodule

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] b;
  aes_gf_inv u_inv (.a_i(a_i), .y_o(b));
  assign y_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] s;
  assign s = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
  aes_gf_inv u_inv (.a_i(s), .y_o(y_o));
endmodule

module aes_128_decrypt (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, EXPAND, INIT, ROUND, FINAL, DONE} fsm_e;

  fsm_e         fsm_q;
  logic [3:0]   rnd_q;
  logic [127:0] state_q, rk_q, pt_q;
  logic         out_valid_q, in_ready_q, busy_q;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key_q, cache_k10_q;
  logic         cache_vld_q;
  logic         cache_hit_c;
  assign cache_hit_c = cache_vld_q && (key == cache_key_q);
`endif

  logic [127:0] isr_c, isb_c, add_c, imc_c, rk_fwd_c, rk_inv_c;
  logic [31:0]  w0, w1, w2, w3, sb_in_c, rot_c, sw_c;
  logic [7:0]   rcon_c;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // multiply by a 4-bit constant built from 1,2,4,8 (covers 9, 11, 13, 14)
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm(a0, 4'd14) ^ gm(a1, 4'd11) ^ gm(a2, 4'd13) ^ gm(a3, 4'd9),
            gm(a0, 4'd9)  ^ gm(a1, 4'd14) ^ gm(a2, 4'd11) ^ gm(a3, 4'd13),
            gm(a0, 4'd13) ^ gm(a1, 4'd9)  ^ gm(a2, 4'd14) ^ gm(a3, 4'd11),
            gm(a0, 4'd11) ^ gm(a1, 4'd13) ^ gm(a2, 4'd9)  ^ gm(a3, 4'd14)};
  endfunction

  // InvShiftRows: byte (row r, col c) takes byte (r, c-r mod 4); byte index = r + 4c
  always_comb begin
    isr_c = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        isr_c[127-8*(r+4*c) -: 8] = state_q[127-8*(r+4*((c-r+4)%4)) -: 8];
  end

  for (genvar i = 0; i < 16; i++) begin : g_isb
    aes_inv_sbox u_isb (.a_i(isr_c[8*i +: 8]), .y_o(isb_c[8*i +: 8]));
  end

  assign add_c = isb_c ^ rk_q;
  always_comb begin
    imc_c = '0;
    for (int c = 0; c < 4; c++) imc_c[127-32*c -: 32] = inv_mix_col(add_c[127-32*c -: 32]);
  end

  // Key schedule: forward step feeds SubWord from w3, backward step from the recovered w3 (w3^w2)
  assign {w0, w1, w2, w3} = rk_q;
  assign sb_in_c = (fsm_q == EXPAND) ? w3 : (w3 ^ w2);
  assign rot_c   = {sb_in_c[23:0], sb_in_c[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_sb
    aes_sbox u_sb (.a_i(rot_c[8*j +: 8]), .y_o(sw_c[8*j +: 8]));
  end

  always_comb begin
    case (rnd_q)
      4'd1:    rcon_c = 8'h01;
      4'd2:    rcon_c = 8'h02;
      4'd3:    rcon_c = 8'h04;
      4'd4:    rcon_c = 8'h08;
      4'd5:    rcon_c = 8'h10;
      4'd6:    rcon_c = 8'h20;
      4'd7:    rcon_c = 8'h40;
      4'd8:    rcon_c = 8'h80;
      4'd9:    rcon_c = 8'h1b;
      4'd10:   rcon_c = 8'h36;
      default: rcon_c = 8'h00;
    endcase
  end

  always_comb begin
    logic [31:0] n0, n1, n2;
    n0 = w0 ^ sw_c ^ {rcon_c, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    rk_fwd_c = {n0, n1, n2, w3 ^ n2};
    rk_inv_c = {w0 ^ sw_c ^ {rcon_c, 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      state_q     <= 128'h0;
      rk_q        <= 128'h0;
      pt_q        <= 128'h0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key_q <= 128'h0;
      cache_k10_q <= 128'h0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        IDLE: if (in_valid && in_ready_q) begin
          state_q    <= ct;
          rk_q       <= key;
          rnd_q      <= 4'd1;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          fsm_q      <= EXPAND;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_hit_c) begin
            rk_q  <= cache_k10_q;
            rnd_q <= 4'd10;
            fsm_q <= INIT;
          end else begin
            cache_key_q <= key;
            cache_vld_q <= 1'b0;
          end
`endif
        end
        EXPAND: begin
          rk_q <= rk_fwd_c;
          if (rnd_q == 4'd10) begin
            fsm_q <= INIT;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_k10_q <= rk_fwd_c;
            cache_vld_q <= 1'b1;
`endif
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        INIT: begin
          state_q <= state_q ^ rk_q;
          rk_q    <= rk_inv_c;
          rnd_q   <= 4'd9;
          fsm_q   <= ROUND;
        end
        ROUND: begin
          state_q <= imc_c;
          rk_q    <= rk_inv_c;
          rnd_q   <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) fsm_q <= FINAL;
        end
        FINAL: begin
          pt_q        <= add_c;
          out_valid_q <= 1'b1;
          fsm_q       <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          fsm_q       <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          rnd_q       <= 4'd0;
          fsm_q       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign pt        = pt_q;
  assign busy      = busy_q;
endmodule
